// File: rtl/nios_pio_in.sv
// nios_pio_in: Avalon-MM slave input PIO for the Nios bus.
// Synchronises and debounces a parallel input bus. Captures selected edges in a
// write-1-to-clear register. Raises a level interrupt for unmasked captured edges.
//
// Ports:
//   clk         system clock, all logic on posedge
//   reset       asynchronous active-high reset
//   address     register word offset (0 DATA, 2 IRQMASK, 3 EDGECAP, others read 0)
//   chipselect  slave select
//   write_n     active-low write strobe, qualified by chipselect
//   writedata   write data
//   readdata    read data, combinational (latency 0)
//   in_port     asynchronous input pins
//   irq         level interrupt, active high
module nios_pio_in #(
    parameter int unsigned WIDTH     = 17,
    parameter int unsigned DEBOUNCE  = 4,
    parameter int unsigned EDGE_TYPE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int unsigned CntW = $clog2(DEBOUNCE + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] stable_dly_q;
    logic [CntW-1:0]  cnt_q [WIDTH];
    logic [CntW-1:0]  cnt_d [WIDTH];
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [1:0]       arm_cnt_q;
    logic             armed_q;

    logic             wr;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] rise, fall, ev;

    // Upper writedata bits are only meaningful when WIDTH is 32.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    assign wr = chipselect & ~write_n;

    // Debounce: while unarmed, stable tracks the synchroniser directly so the
    // pin level present at reset release is adopted without debouncing.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_d[i] = '0;
        end
        if (!armed_q) begin
            stable_d = sync2_q;
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (sync2_q[i] == stable_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CntMax) begin
                    stable_d[i] = sync2_q[i];
                    cnt_d[i]    = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Edge detect and capture. Events are masked until armed so that the
    // adoption of the initial pin level is never seen as an edge.
    always_comb begin
        rise = stable_q & ~stable_dly_q;
        fall = ~stable_q & stable_dly_q;
        case (EDGE_TYPE)
            0:       ev = rise;
            1:       ev = fall;
            default: ev = rise | fall;
        endcase
        if (!armed_q) begin
            ev = '0;
        end
        clr    = (wr && address == 3'd3) ? writedata[WIDTH-1:0] : '0;
        cap_d  = (cap_q & ~clr) | ev;  // set wins over same-cycle clear
        mask_d = (wr && address == 3'd2) ? writedata[WIDTH-1:0] : mask_q;
    end

    // armed rises only after stable and its delayed copy both hold the
    // synchronised pin level (edges 1-4 after release run unarmed).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            mask_q       <= '0;
            cap_q        <= '0;
            arm_cnt_q    <= '0;
            armed_q      <= 1'b0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q      <= in_port;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            mask_q       <= mask_d;
            cap_q        <= cap_d;
            if (arm_cnt_q != 2'd3) begin
                arm_cnt_q <= arm_cnt_q + 2'd1;
            end
            if (arm_cnt_q == 2'd3) begin
                armed_q <= 1'b1;
            end
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            3'd0:    readdata[WIDTH-1:0] = stable_q;
            3'd2:    readdata[WIDTH-1:0] = mask_q;
            3'd3:    readdata[WIDTH-1:0] = cap_q;
            default: readdata = '0;
        endcase
    end

    assign irq = |(cap_q & mask_q);

endmodule

// File: tb/tb_nios_pio_in.sv
module tb_nios_pio_in;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [16:0] in_port;
    logic [31:0] rd_rise, rd_any;
    logic        irq_rise, irq_any;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
        bit          any;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        string       name;
        bit          is_wr;
        logic [2:0]  addr;
        logic [31:0] data;
    } vec_t;
    vec_t vecs[14];

    nios_pio_in #(.WIDTH(17), .DEBOUNCE(4), .EDGE_TYPE(0)) u_rise (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_rise),
        .in_port(in_port), .irq(irq_rise)
    );

    nios_pio_in #(.WIDTH(17), .DEBOUNCE(4), .EDGE_TYPE(2)) u_any (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_any),
        .in_port(in_port), .irq(irq_any)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Read: expected value queued when the read is driven, popped when sampled.
    task automatic rd(input bit any, input logic [2:0] a, input logic [31:0] exp,
                      input string name);
        sb_t e;
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        sb_q.push_back('{name, exp, any});
        #1;
        e = sb_q.pop_front();
        check(e.name, e.any ? rd_any : rd_rise, e.exp);
        chipselect = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic chk_irq(input string name, input logic exp);
        check({name, "_rise"}, {31'd0, irq_rise}, {31'd0, exp});
        check({name, "_any"}, {31'd0, irq_any}, {31'd0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{"rd_off1",       1'b0, 3'd1, 32'h0};
        vecs[1]  = '{"rd_off5",       1'b0, 3'd5, 32'h0};
        vecs[2]  = '{"rd_off7",       1'b0, 3'd7, 32'h0};
        vecs[3]  = '{"wr_off0",       1'b1, 3'd0, 32'hFFFF_FFFF};
        vecs[4]  = '{"data_after_w0", 1'b0, 3'd0, 32'h0001_8};
        vecs[5]  = '{"wr_off1",       1'b1, 3'd1, 32'hFFFF_FFFF};
        vecs[6]  = '{"rd_off1_after", 1'b0, 3'd1, 32'h0};
        vecs[7]  = '{"wr_off6",       1'b1, 3'd6, 32'hFFFF_FFFF};
        vecs[8]  = '{"rd_off6_after", 1'b0, 3'd6, 32'h0};
        vecs[9]  = '{"wr_mask_all",   1'b1, 3'd2, 32'hFFFF_FFFF};
        vecs[10] = '{"rd_mask_all",   1'b0, 3'd2, 32'h0001_FFFF};
        vecs[11] = '{"wr_mask_10",    1'b1, 3'd2, 32'h0000_0010};
        vecs[12] = '{"rd_mask_10",    1'b0, 3'd2, 32'h0000_0010};
        vecs[13] = '{"rd_cap_10",     1'b0, 3'd3, 32'h0000_0010};

        reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; in_port = 17'h1FFFF;

        // 1: pins high through reset
        tick(3);
        rd(0, 3'd0, 32'h0, "rst_data");
        chk_irq("rst_irq", 1'b0);
        reset = 1'b0;
        tick();
        tick();
        rd(0, 3'd0, 32'h0, "data_edge2");
        tick();
        rd(0, 3'd0, 32'h1FFFF, "data_edge3");
        rd(1, 3'd0, 32'h1FFFF, "data_edge3_any");
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_irq("arm_irq", 1'b0);
        end
        rd(0, 3'd3, 32'h0, "arm_cap_rise");
        rd(1, 3'd3, 32'h0, "arm_cap_any");
        in_port = 17'h0;
        tick(12);
        rd(0, 3'd3, 32'h0, "fall_cap_rise");
        rd(1, 3'd3, 32'h1FFFF, "fall_cap_any");
        wr(3'd3, 32'h1FFFF);
        rd(1, 3'd3, 32'h0, "clr_all_any");

        // 2: step on bit 3, latency
        wr(3'd2, 32'h8);
        in_port = 17'h00008;
        for (int e = 1; e <= 7; e++) begin
            tick();
            rd(0, 3'd0, (e >= 6) ? 32'h8 : 32'h0, $sformatf("step_data_e%0d", e));
            rd(0, 3'd3, (e >= 7) ? 32'h8 : 32'h0, $sformatf("step_cap_e%0d", e));
            check($sformatf("step_irq_e%0d", e), {31'd0, irq_rise}, (e >= 7) ? 32'd1 : 32'd0);
        end
        rd(1, 3'd3, 32'h8, "step_cap_any");

        // 3: glitch rejection then 4-cycle pulse
        in_port = 17'h00009;
        tick(3);
        in_port = 17'h00008;
        tick(12);
        rd(0, 3'd0, 32'h8, "glitch_data");
        rd(0, 3'd3, 32'h8, "glitch_cap_rise");
        rd(1, 3'd3, 32'h8, "glitch_cap_any");
        in_port = 17'h00009;
        tick(4);
        in_port = 17'h00008;
        tick(12);
        rd(0, 3'd0, 32'h8, "pulse_data");
        rd(1, 3'd3, 32'h9, "pulse_cap_any");
        rd(0, 3'd3, 32'h9, "pulse_cap_rise");

        // 4: write-1-to-clear, then clear colliding with a new edge
        wr(3'd3, 32'h1);
        rd(0, 3'd3, 32'h8, "w1c_rise");
        rd(1, 3'd3, 32'h8, "w1c_any");
        in_port = 17'h00009;
        tick(6);
        rd(0, 3'd0, 32'h9, "coll_data");
        rd(0, 3'd3, 32'h8, "coll_cap_pre");
        wr(3'd3, 32'h1);
        rd(0, 3'd3, 32'h9, "coll_cap_rise");
        rd(1, 3'd3, 32'h9, "coll_cap_any");
        in_port = 17'h00008;
        tick(12);
        wr(3'd3, 32'h1FFFF);
        rd(0, 3'd3, 32'h0, "clr2_rise");
        rd(1, 3'd3, 32'h0, "clr2_any");

        // 5: mask gating and register map
        wr(3'd2, 32'h0);
        in_port = 17'h00018;
        tick(12);
        rd(0, 3'd3, 32'h10, "mask0_cap");
        rd(1, 3'd3, 32'h10, "mask0_cap_any");
        chk_irq("mask0_irq", 1'b0);
        wr(3'd2, 32'h10);
        chk_irq("mask10_irq", 1'b1);
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].is_wr) wr(vecs[i].addr, vecs[i].data);
            else rd(0, vecs[i].addr, vecs[i].data, vecs[i].name);
        end

        // 6: reset mid-operation with a capture pending and a count at 2
        chk_irq("pre_rst_irq", 1'b1);
        in_port = 17'h00038;
        tick(4);
        reset = 1'b1;
        #1;
        rd(0, 3'd0, 32'h0, "mid_rst_data");
        rd(0, 3'd2, 32'h0, "mid_rst_mask");
        rd(0, 3'd3, 32'h0, "mid_rst_cap");
        rd(1, 3'd3, 32'h0, "mid_rst_cap_any");
        chk_irq("mid_rst_irq", 1'b0);
        tick(2);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_irq("post_rst_irq", 1'b0);
        end
        rd(0, 3'd3, 32'h0, "post_rst_cap");
        rd(1, 3'd3, 32'h0, "post_rst_cap_any");
        rd(0, 3'd0, 32'h38, "post_rst_data");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
